// File: rtl/adc3664_spi_master.sv
// adc3664_spi_master
// SPI master that serialises 24-bit ADC3664 configuration frames
// {rw, 3'b000, addr[11:0], data[7:0]}, MSB first. SCLK = CLK / (2*CLK_DIV).
// Optional feature macro: SPI_MASTER_READBACK_EN
//   defined   : read frames release SDIO for the 8 data bits and capture rdata
//   undefined : SDIO is driven for all 24 bits (data bits are 0 on reads),
//               rdata is tied to 8'h00; frame timing is the same in both builds

module adc3664_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic        rw,
  input  logic [11:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        SCLK,
  output logic        SEN,
  inout  wire         SDIO
);

  // state | meaning
  // IDLE  | SEN high, SDIO released, waiting for start
  // SETUP | SEN low, SCLK low, bit 23 on SDIO for CLK_DIV cycles
  // SHIFT | 24 SCLK periods (high phase, then low phase with next bit)
  // HOLD  | SEN low, SCLK low for CLK_DIV cycles before SEN rises

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_bit;
  logic             r_phase_hi;
  logic [23:0]      r_shift;
  logic             r_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       w_bit_nxt;
  logic             w_phase_nxt;
  logic             w_load;
  logic             w_fall;
  logic             w_finish;
  logic             w_release;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_TC);

  // State, half-period counter, bit counter and SCLK phase registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= 5'd23;
      r_phase_hi <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_phase_hi <= w_phase_nxt;
    end
  end

  // Next-state logic and per-cycle event strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_phase_nxt = r_phase_hi;
    w_load      = 1'b0;
    w_fall      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SETUP;
          w_bit_nxt   = 5'd23;
          w_phase_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_tc) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
          w_phase_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!w_tc) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
          if (r_phase_hi) begin
            // last cycle of the high phase: SCLK falls on this edge
            w_phase_nxt = 1'b0;
            w_fall      = 1'b1;
          end else if (r_bit == 5'd0) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_bit_nxt   = r_bit - 5'd1;
            w_phase_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_tc) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered pin outputs and the transmit shift register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_shift <= 24'h000000;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_busy <= (w_state_nxt != ST_IDLE);
      r_sclk <= (w_state_nxt == ST_SHIFT) && w_phase_nxt;
      if (w_load) begin
        // data bits are zero on reads so the non-readback build sends 8'h00
        r_shift <= {rw, 3'b000, addr, (rw ? 8'h00 : wdata)};
        r_oe    <= 1'b1;
      end else if (w_finish) begin
        r_oe <= 1'b0;
      end else if (w_fall) begin
        r_shift <= {r_shift[22:0], 1'b0};
        if (w_release) begin
          r_oe <= 1'b0;
        end
      end
    end
  end

`ifdef SPI_MASTER_READBACK_EN
  logic       r_rw;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic       w_sample;

  // hand SDIO to the slave on the falling edge that ends bit 8
  assign w_release = w_fall && r_rw && (r_bit == 5'd8);
  assign w_sample  = w_fall && (r_bit <= 5'd7);

  // Read-back capture: sample in the last high-phase cycle, publish at frame end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_rw    <= 1'b0;
      r_rx    <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      if (w_load) begin
        r_rw <= rw;
      end
      if (w_sample && r_rw) begin
        r_rx <= {r_rx[6:0], SDIO};
      end
      if (w_finish && r_rw) begin
        r_rdata <= r_rx;
      end
    end
  end

  assign rdata = r_rdata;
`else
  assign w_release = 1'b0;
  assign rdata     = 8'h00;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign SCLK = r_sclk;
  assign SEN  = ~r_busy;
  assign SDIO = r_oe ? r_shift[23] : 1'bz;

endmodule
